// File: rtl/kyber_pkg.sv
// Shared constants, eta encodings and FSM state type for the Kyber CBD sampler.
// Build option CBD_ETA3_EN enables eta=3 support, which raises ETA_MAX to 3.
package kyber_pkg;

    localparam int KYBER_N = 256;
    localparam int CBD_CW  = 3;

    localparam logic [1:0] ETA_2 = 2'd2;
    localparam logic [1:0] ETA_3 = 2'd3;

`ifdef CBD_ETA3_EN
    localparam int ETA_MAX = 3;
`else
    localparam int ETA_MAX = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cbd_state_t;

    function automatic logic eta_supported(input logic [1:0] eta);
`ifdef CBD_ETA3_EN
        return (eta == ETA_2) || (eta == ETA_3);
`else
        return (eta == ETA_2);
`endif
    endfunction

endpackage

// File: rtl/cbd_stream_if.sv
// Stream bundle for cbd_stream: PRF byte input and coefficient beat output.
interface cbd_stream_if #(
    parameter int IW = 64,
    parameter int NC = 16,
    parameter int CW = 3
);
    logic [IW-1:0]    i_ibytes;
    logic             i_ibytes_valid;
    logic             o_ibytes_ready;
    logic [NC*CW-1:0] o_coeffs;
    logic             o_coeffs_valid;
    logic             i_coeffs_ready;

    modport slave (
        input  i_ibytes, i_ibytes_valid, i_coeffs_ready,
        output o_ibytes_ready, o_coeffs, o_coeffs_valid
    );

    modport master (
        output i_ibytes, i_ibytes_valid, i_coeffs_ready,
        input  o_ibytes_ready, o_coeffs, o_coeffs_valid
    );
endinterface

// File: rtl/cbd_bitbuf.sv
// Bit FIFO for the CBD sampler: oldest stream bit sits at index 0, words append above lvl.
// Data bits are not reset; everything at or above lvl is masked off on each update.
module cbd_bitbuf #(
    parameter int IW     = 64,
    parameter int BUF_W  = 128,
    parameter int HEAD_W = 64,
    parameter int LW     = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [IW-1:0]     i_word,
    input  logic              i_pop,
    input  logic [LW-1:0]     i_pop_bits,
    output logic [LW-1:0]     o_lvl,
    output logic [HEAD_W-1:0] o_head
);

    localparam logic [LW-1:0] IW_L = LW'(IW);

    logic [BUF_W-1:0] buf_q, buf_d, shifted, keep_mask, word_ext;
    logic [IW-1:0]    word_lsbf;
    logic [LW-1:0]    lvl_q, lvl_d, base;

    // Byte 0 is the top byte of the word; within a byte the LSB comes first.
    always_comb begin
        word_lsbf = '0;
        for (int k = 0; k < IW; k++) begin
            word_lsbf[k] = i_word[IW - 8*(k/8) - 8 + (k%8)];
        end
    end

    always_comb begin
        base      = i_pop ? (lvl_q - i_pop_bits) : lvl_q;
        shifted   = i_pop ? (buf_q >> i_pop_bits) : buf_q;
        keep_mask = ~({BUF_W{1'b1}} << base);
        word_ext  = {{(BUF_W-IW){1'b0}}, word_lsbf} << base;
        buf_d     = shifted & keep_mask;
        lvl_d     = base;
        if (i_push) begin
            buf_d = buf_d | word_ext;
            lvl_d = base + IW_L;
        end
        if (i_clr) begin
            lvl_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    assign o_lvl  = lvl_q;
    assign o_head = buf_q[HEAD_W-1:0];

endmodule

// File: rtl/cbd_stream.sv
// Streaming centered-binomial sampler: PRF bytes in, NC coefficients per beat out.
// eta=3 support depends on the CBD_ETA3_EN build option (see kyber_pkg).
//
// state   | meaning
// IDLE    | waiting for i_start; bad eta pulses o_err
// RUN     | filling bit buffer, emitting beats until N coefficients handed off
// DONE    | one-cycle o_done; leftover buffer bits discarded
module cbd_stream
    import kyber_pkg::*;
#(
    parameter int IW = 64,
    parameter int NC = 16,
    parameter int CW = CBD_CW,
    parameter int N  = KYBER_N
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [1:0]       i_eta,
    cbd_stream_if.slave      bus,
    output logic             o_done,
    output logic             o_err
);

    localparam int BUF_W  = IW + 2*ETA_MAX*NC;
    localparam int HEAD_W = 2*ETA_MAX*NC;
    localparam int LW     = $clog2(BUF_W + 1);
    localparam int NB     = N / NC;
    localparam int BW     = $clog2(NB + 1);

    localparam logic [LW-1:0] BEAT2 = LW'(4*NC);
    localparam logic [LW-1:0] BEAT3 = LW'(6*NC);
    localparam logic [LW-1:0] ROOM  = LW'(BUF_W - IW);
    localparam logic [BW-1:0] NB_L  = BW'(NB);

    cbd_state_t       state_q, state_d;
    logic [1:0]       eta_q;
    logic [BW-1:0]    beat_cnt_q;
    logic [LW-1:0]    lvl, need;
    logic [HEAD_W-1:0] head;
    logic [NC*CW-1:0] coeffs_d;
    logic [5:0]       bits;
    logic             push, emit, out_hs, err_d, start_ok;

    function automatic logic [CW-1:0] cbd_coeff(input logic [5:0] b6, input logic eta3);
        logic [2:0]        a, b;
        logic signed [3:0] diff;
        if (eta3) begin
            a = 3'(b6[0]) + 3'(b6[1]) + 3'(b6[2]);
            b = 3'(b6[3]) + 3'(b6[4]) + 3'(b6[5]);
        end else begin
            a = 3'(b6[0]) + 3'(b6[1]);
            b = 3'(b6[2]) + 3'(b6[3]);
        end
        diff = signed'({1'b0, a}) - signed'({1'b0, b});
        return CW'(diff);
    endfunction

    assign need   = (eta_q == ETA_3) ? BEAT3 : BEAT2;
    assign out_hs = bus.o_coeffs_valid && bus.i_coeffs_ready;
    assign bus.o_ibytes_ready = i_rstn && (state_q == ST_RUN) && (lvl <= ROOM) && (beat_cnt_q < NB_L);
    assign push   = bus.o_ibytes_ready && bus.i_ibytes_valid;
    assign emit   = (state_q == ST_RUN) && (beat_cnt_q < NB_L) && (lvl >= need) &&
                    (!bus.o_coeffs_valid || bus.i_coeffs_ready);
    assign o_done = (state_q == ST_DONE);

    cbd_bitbuf #(
        .IW     (IW),
        .BUF_W  (BUF_W),
        .HEAD_W (HEAD_W),
        .LW     (LW)
    ) u_bitbuf (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_clr      (state_q == ST_DONE),
        .i_push     (push),
        .i_word     (bus.i_ibytes),
        .i_pop      (emit),
        .i_pop_bits (need),
        .o_lvl      (lvl),
        .o_head     (head)
    );

    always_comb begin
        coeffs_d = '0;
        bits     = '0;
        for (int j = 0; j < NC; j++) begin
`ifdef CBD_ETA3_EN
            if (eta_q == ETA_3) begin
                bits = head[6*j +: 6];
            end else begin
                bits = {2'b00, head[4*j +: 4]};
            end
`else
            bits = {2'b00, head[4*j +: 4]};
`endif
            coeffs_d[NC*CW-1 - j*CW -: CW] = cbd_coeff(bits, eta_q == ETA_3);
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        start_ok = eta_supported(i_eta);
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (start_ok) state_d = ST_RUN;
                    else          err_d   = 1'b1;
                end
            end
            // The output register only ever holds the newest beat, so a handshake
            // with every beat loaded is the hand-off of coefficient N.
            ST_RUN:  if (out_hs && (beat_cnt_q == NB_L)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q            <= ST_IDLE;
            eta_q              <= '0;
            beat_cnt_q         <= '0;
            bus.o_coeffs       <= '0;
            bus.o_coeffs_valid <= 1'b0;
            o_err              <= 1'b0;
        end else begin
            state_q <= state_d;
            o_err   <= err_d;
            if ((state_q == ST_IDLE) && i_start && start_ok) begin
                eta_q      <= i_eta;
                beat_cnt_q <= '0;
            end
            if (emit) begin
                bus.o_coeffs       <= coeffs_d;
                bus.o_coeffs_valid <= 1'b1;
                beat_cnt_q         <= beat_cnt_q + 1'b1;
            end else if (out_hs) begin
                bus.o_coeffs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbd_stream.sv
// Self-checking bench for cbd_stream: directed sequence with randomized data and
// handshakes, checked against a bit-level CBD reference model.
module tb_cbd_stream;
    import kyber_pkg::*;

    localparam int IW = 64;
    localparam int NC = 16;
    localparam int CW = 3;
    localparam int N  = 256;
    localparam int NB = N / NC;
`ifdef CBD_ETA3_EN
    localparam int ETA_MAX_TB = 3;
`else
    localparam int ETA_MAX_TB = 2;
`endif
    localparam int BUF_W  = IW + 2*ETA_MAX_TB*NC;
    localparam int BUDGET = 3000;

    logic       i_clk   = 1'b0;
    logic       i_rstn  = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_eta   = 2'd0;
    logic       o_done, o_err;

    cbd_stream_if #(.IW(IW), .NC(NC), .CW(CW)) bus ();

    cbd_stream #(.IW(IW), .NC(NC), .CW(CW), .N(N)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_start (i_start),
        .i_eta   (i_eta),
        .bus     (bus.slave),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream [0:191];
    int         exp_c  [0:N-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sbit(input int k);
        logic [7:0] by;
        by = stream[k/8];
        return int'(by[k%8]);
    endfunction

    // Reference: fill the byte stream, then derive every coefficient from its bits.
    task automatic gen(input int eta, input int mode, output int nwords);
        int a, b;
        nwords = N*2*eta/IW;
        for (int i = 0; i < nwords*8; i++) begin
            case (mode)
                0: stream[i] = 8'h00;
                1: stream[i] = 8'h03;
                2: stream[i] = (i%3 == 0) ? 8'hC7 : ((i%3 == 1) ? 8'h71 : 8'h1C);
                3: stream[i] = 8'hFF;
                default: stream[i] = 8'($urandom);
            endcase
        end
        for (int j = 0; j < N; j++) begin
            a = 0;
            b = 0;
            for (int t = 0; t < eta; t++) begin
                a += sbit(2*eta*j + t);
                b += sbit(2*eta*j + eta + t);
            end
            exp_c[j] = a - b;
        end
    endtask

    function automatic logic [IW-1:0] word_at(input int w);
        logic [IW-1:0] v;
        v = '0;
        for (int b = 0; b < IW/8; b++) v[IW-1-8*b -: 8] = stream[w*8 + b];
        return v;
    endfunction

    function automatic logic [NC*CW-1:0] exp_beat(input int beat);
        logic [NC*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[NC*CW-1 - i*CW -: CW] = CW'(exp_c[beat*NC + i]);
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"}, 64'(bus.o_coeffs_valid), 64'd0);
        chk({tag, " coeffs"}, 64'(bus.o_coeffs), 64'd0);
        chk({tag, " done"}, 64'(o_done), 64'd0);
        chk({tag, " err"}, 64'(o_err), 64'd0);
        chk({tag, " ready"}, 64'(bus.o_ibytes_ready), 64'd0);
    endtask

    task automatic reject_test(input int eta, input string tag);
        i_eta   = 2'(eta);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({tag, " err pulse"}, 64'(o_err), 64'd1);
        chk({tag, " idle ready"}, 64'(bus.o_ibytes_ready), 64'd0);
        @(negedge i_clk);
        chk({tag, " err clear"}, 64'(o_err), 64'd0);
        chk({tag, " still idle"}, 64'(bus.o_ibytes_ready), 64'd0);
    endtask

    // bp: 0 always ready, 1 five-cycle stall at beat 4, 2 random handshakes.
    task automatic run_poly(input int eta, input int mode, input int bp, input int abort_at,
                            input string tag);
        int               nwords, w_idx, taken, cyc, stall, lvl_m, loaded;
        logic             was_stalled, exp_rdy;
        logic [NC*CW-1:0] held;
        gen(eta, mode, nwords);
        i_eta   = 2'(eta);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_eta   = 2'd1;
        w_idx = 0; taken = 0; cyc = 0; stall = 0;
        was_stalled = 1'b0;
        held = '0;
        while (taken < NB && cyc < BUDGET) begin
            if (was_stalled) chk({tag, " hold"}, 64'(bus.o_coeffs), 64'(held));
            loaded  = taken + (bus.o_coeffs_valid ? 1 : 0);
            lvl_m   = w_idx*IW - loaded*2*eta*NC;
            exp_rdy = (loaded < NB) && (lvl_m <= BUF_W - IW);
            chk({tag, " ibytes_ready"}, 64'(bus.o_ibytes_ready), 64'(exp_rdy));
            chk({tag, " done low"}, 64'(o_done), 64'd0);
            chk({tag, " err low"}, 64'(o_err), 64'd0);
            if (abort_at >= 0 && taken == abort_at) begin
                i_rstn = 1'b0;
                bus.i_ibytes_valid = 1'b0;
                #1;
                chk({tag, " ready in reset"}, 64'(bus.o_ibytes_ready), 64'd0);
                @(negedge i_clk);
                check_reset_outputs({tag, " abort"});
                i_rstn = 1'b1;
                @(negedge i_clk);
                chk({tag, " ready after reset"}, 64'(bus.o_ibytes_ready), 64'd0);
                return;
            end
            bus.i_ibytes_valid = (w_idx < nwords) && (bp != 2 || $urandom_range(0, 3) != 0);
            bus.i_ibytes       = (w_idx < nwords) ? word_at(w_idx) : {$urandom, $urandom};
            case (bp)
                1: begin
                    if (taken == 4 && stall < 5 && bus.o_coeffs_valid) begin
                        bus.i_coeffs_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.i_coeffs_ready = 1'b1;
                    end
                end
                2: bus.i_coeffs_ready = ($urandom_range(0, 2) != 0);
                default: bus.i_coeffs_ready = 1'b1;
            endcase
            i_start = (cyc == 10);
            if (bus.o_ibytes_ready && bus.i_ibytes_valid) w_idx++;
            if (bus.o_coeffs_valid && bus.i_coeffs_ready) begin
                chk({tag, " beat"}, 64'(bus.o_coeffs), 64'(exp_beat(taken)));
                taken++;
            end
            was_stalled = bus.o_coeffs_valid && !bus.i_coeffs_ready;
            held        = bus.o_coeffs;
            @(negedge i_clk);
            cyc++;
        end
        i_start = 1'b0;
        bus.i_ibytes_valid = 1'b0;
        chk({tag, " beats taken"}, 64'(taken), 64'(NB));
        chk({tag, " words taken"}, 64'(w_idx), 64'(nwords));
        chk({tag, " done pulse"}, 64'(o_done), 64'd1);
        chk({tag, " valid clear"}, 64'(bus.o_coeffs_valid), 64'd0);
        chk({tag, " ready in done"}, 64'(bus.o_ibytes_ready), 64'd0);
        @(negedge i_clk);
        chk({tag, " done clear"}, 64'(o_done), 64'd0);
        chk({tag, " back idle"}, 64'(bus.o_ibytes_ready), 64'd0);
    endtask

    initial begin
        bus.i_ibytes       = '0;
        bus.i_ibytes_valid = 1'b0;
        bus.i_coeffs_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        check_reset_outputs("por");
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("por release ready", 64'(bus.o_ibytes_ready), 64'd0);

        reject_test(1, "eta1_reject");
        reject_test(0, "eta0_reject");

        run_poly(2, 0, 0, -1, "eta2_zero");
        run_poly(2, 1, 0, -1, "eta2_03");
        run_poly(2, 4, 1, -1, "eta2_stall");
        run_poly(2, 4, 2, -1, "eta2_rand");
`ifdef CBD_ETA3_EN
        run_poly(3, 2, 0, -1, "eta3_pattern");
        run_poly(3, 3, 0, -1, "eta3_ones");
        run_poly(3, 4, 2, -1, "eta3_rand");
`else
        reject_test(3, "eta3_reject");
`endif
        run_poly(2, 4, 0, 7, "eta2_abort");
        run_poly(2, 4, 0, -1, "eta2_after_abort");
        run_poly(2, 4, 2, -1, "eta2_rand2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbd_stream.md
CBD_STREAM -- requirements
Module: cbd_stream

Interface
REQ-001 Parameter IW, default 64: input word width in bits; multiple of 8; byte 0 is i_ibytes[IW-1:IW-8].
REQ-002 Parameter NC, default 16: coefficients per output beat.
REQ-003 Parameter CW, default 3: coefficient width, two's complement.
REQ-004 Parameter N, default 256: coefficients per polynomial; multiple of NC.
REQ-005 i_clk  in  1  clock; single clock domain.
REQ-006 i_rstn  in  1  reset; synchronous, active-low.
REQ-007 i_start  in  1  one-cycle pulse that begins a polynomial; sampled only in IDLE.
REQ-008 i_eta  in  2  noise parameter; captured on an accepted i_start.
REQ-009 i_ibytes  in  IW  PRF byte stream word.
REQ-010 i_ibytes_valid / o_ibytes_ready  in/out  1  input handshake; a word transfers when both are high.
REQ-011 o_coeffs  out  NC*CW  coefficient beat; coefficient 0 in [NC*CW-1 -: CW].
REQ-012 o_coeffs_valid / i_coeffs_ready  out/in  1  output handshake.
REQ-013 o_done  out  1  one-cycle pulse at end of polynomial.
REQ-014 o_err  out  1  one-cycle pulse on rejected i_start.

Function
REQ-015 Bit order: the stream is bytes in order, and each byte LSB first; coefficient j uses stream bits [2*eta*j, 2*eta*j+2*eta).
REQ-016 Coefficient value: a - b, where a is the popcount of the first eta bits and b is the popcount of the next eta bits; the result is sign-extended to CW bits.
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE->RUN on i_start with eta in {2,3}.
REQ-019 On i_start with any other eta: stay in IDLE and pulse o_err for 1 cycle.
REQ-020 RUN->DONE on the output handshake that completes coefficient N.
REQ-021 DONE->IDLE after 1 cycle; o_done is high exactly during DONE.
REQ-022 Bit buffer: capacity BUF_W = IW + 2*ETA_MAX*NC bits, with fill level lvl.
  - o_ibytes_ready = RUN && lvl <= BUF_W-IW && fewer than N coefficients have been emitted; it is decided from current lvl only.
REQ-023 Emit rule: when in RUN, lvl >= 2*eta*NC and (!o_coeffs_valid || i_coeffs_ready), then at the next edge:
  - load o_coeffs from the oldest bits;
  - set o_coeffs_valid;
  - decrement lvl by 2*eta*NC.
REQ-024 An input transfer and an emission in the same cycle both take effect: lvl' = lvl + IW - 2*eta*NC.
REQ-025 o_coeffs is held stable while o_coeffs_valid && !i_coeffs_ready; no beat is lost or duplicated under backpressure.
REQ-026 o_coeffs_valid clears on a handshake when no new beat is emitted in that cycle.
REQ-027 Latency: the first beat is valid on the edge after the edge that accepts the word making lvl >= 2*eta*NC.
  - eta=2, IW=64: the cycle after the 1st input beat.
  - eta=3, IW=64: the cycle after the 2nd input beat.
REQ-028 Bits left after coefficient N are discarded; lvl clears in DONE.
REQ-029 i_eta changes during RUN are ignored.
REQ-030 Further i_start pulses during RUN are ignored.

Reset
REQ-031 When i_rstn is low at an edge, all of the following reset to 0, including mid-polynomial: state=IDLE, lvl, coefficient counter, o_coeffs, o_coeffs_valid, o_done, o_err.
REQ-032 o_ibytes_ready is low while i_rstn is low and in the cycle following reset.
REQ-033 Buffer data bits need no reset.

Configuration
REQ-034 Macro CBD_ETA3_EN defined: eta=3 is supported, ETA_MAX=3, and BUF_W=IW+96 at defaults.
REQ-035 Macro CBD_ETA3_EN undefined: ETA_MAX=2, BUF_W=IW+64, and i_start with eta=3 is rejected per REQ-019.

Structure
REQ-036 Shared package kyber_pkg holds:
  - constants KYBER_N=256 and CBD_CW=3;
  - eta encodings;
  - FSM state typedef for cbd_stream.
REQ-037 Sub-module cbd_bitbuf holds the bit buffer, append/consume logic and lvl; cbd_stream holds the FSM, counter, coefficient arithmetic and output register.

Verification
REQ-038 eta=2, 16 input words of all 0x00, i_coeffs_ready=1 -> 16 beats of all-zero o_coeffs, o_done 1 cycle after the 16th beat.
REQ-039 eta=2, every byte 0x03 -> each beat alternates coefficients 2,0 (3'b010, 3'b000).
REQ-040 eta=3, byte pattern 0xC7,0x71,0x1C repeated for 24 words -> all 256 coefficients = 3 (3'b011); all-0xFF input -> all 0.
REQ-041 eta=2, i_coeffs_ready held low for 5 cycles mid-stream:
  - o_coeffs is stable throughout;
  - o_ibytes_ready drops once lvl > BUF_W-IW;
  - the coefficient sequence matches the reference model with no loss.
REQ-042 i_start with eta=1 -> o_err pulses for 1 cycle and the block stays in IDLE; i_rstn low at beat 7 -> all outputs 0, and a new i_start produces a correct full polynomial.
